// File: rtl/pwm_pulse_ctrl.sv
// pwm_pulse_ctrl: software register bank, prescaled tick generator and
// double-buffered ON/OFF update front-end for the downstream PWM core.
`timescale 1ns/1ps
module pwm_pulse_ctrl #(
  parameter logic [7:0] DEFAULT_PRESCALE = 8'd99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       pwm_out,
  output logic       pwm_pulse,
  output logic [7:0] pwm_on_reg,
  output logic [7:0] pwm_off_reg,
  output logic       sync_reset
);

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_ON_STAGE  = 2'd1;
  localparam logic [1:0] ADDR_OFF_STAGE = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE  = 2'd3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic       enable;
  logic [7:0] on_stage;
  logic [7:0] off_stage;
  logic [7:0] prescale;
  logic [7:0] cnt;
  logic       pwm_out_d1;
  logic [0:0] state;
  logic [0:0] state_next;

  logic ctrl_we;
  logic update_req;
  logic pending;
  logic pwm_rise;
  logic commit;

  assign ctrl_we    = we && (addr == ADDR_CTRL);
  assign update_req = ctrl_we && wdata[1];
  assign pending    = (state == ST_PENDING);
  assign pwm_rise   = pwm_out && !pwm_out_d1;
  // An idle core (ON count 0) never rises, and a disabled block has no
  // period to tear, so either lets the staged values through at once.
  assign commit     = pending && (!enable || pwm_rise || (pwm_on_reg == 8'd0));

  // Software-visible register bank; update_req and force_rst are strobes, not stored.
  // NOTE: reset is asynchronous, so every flop in this block sits in the sensitivity list edge and must have a reset branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable    <= 1'b0;
      on_stage  <= 8'd0;
      off_stage <= 8'd0;
      prescale  <= DEFAULT_PRESCALE;
    end else if (we) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
      case (addr)
        ADDR_CTRL:      enable    <= wdata[0];
        ADDR_ON_STAGE:  on_stage  <= wdata;
        ADDR_OFF_STAGE: off_stage <= wdata;
        default:        prescale  <= wdata;
      endcase
    end
  end

  // Prescaler: down-counter that emits a one-cycle tick and reloads on zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= DEFAULT_PRESCALE;
      pwm_pulse <= 1'b0;
    end else if (!enable) begin
      cnt       <= prescale;
      pwm_pulse <= 1'b0;
    end else if (cnt == 8'd0) begin
      cnt       <= prescale;
      pwm_pulse <= 1'b1;
    end else begin
      cnt       <= cnt - 8'd1;
      pwm_pulse <= 1'b0;
    end
  end

  // Update FSM next state: a new request while committing keeps the request alive.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:    if (update_req) state_next = ST_PENDING;
      default:    if (commit && !update_req) state_next = ST_IDLE;
    endcase
  end

  // Update FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Active ON/OFF values: loaded from the staging registers only on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_on_reg  <= 8'd0;
      pwm_off_reg <= 8'd0;
    end else if (commit) begin
      pwm_on_reg  <= on_stage;
      pwm_off_reg <= off_stage;
    end
  end

  // Core clear: pulse on force_rst or on an enable 1->0 transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_reset <= 1'b0;
    else       sync_reset <= ctrl_we && (wdata[2] || (enable && !wdata[0]));
  end

  // Delayed copy of the core output for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_out_d1 <= 1'b0;
    else       pwm_out_d1 <= pwm_out;
  end

  // Combinational register readback.
  always_comb begin
    rdata = 8'd0;
    case (addr)
      ADDR_CTRL:      rdata = {6'b0, pending, enable};
      ADDR_ON_STAGE:  rdata = on_stage;
      ADDR_OFF_STAGE: rdata = off_stage;
      ADDR_PRESCALE:  rdata = prescale;
      default:        rdata = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_pwm_pulse_ctrl.sv
// Testbench for pwm_pulse_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pwm_pulse_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       pwm_out;
  logic       pwm_pulse;
  logic [7:0] pwm_on_reg;
  logic [7:0] pwm_off_reg;
  logic       sync_reset;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwm_pulse_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .pwm_out    (pwm_out),
    .pwm_pulse  (pwm_pulse),
    .pwm_on_reg (pwm_on_reg),
    .pwm_off_reg(pwm_off_reg),
    .sync_reset (sync_reset)
  );

  // Reference model state
  bit         m_enable, m_pending, m_pulse, m_sync, m_pout_prev;
  logic [7:0] m_on_stage, m_off_stage, m_prescale, m_on, m_off, m_cnt;

  task automatic model_reset();
    m_enable = 0; m_pending = 0; m_pulse = 0; m_sync = 0; m_pout_prev = 0;
    m_on_stage = 8'd0; m_off_stage = 8'd0; m_on = 8'd0; m_off = 8'd0;
    m_prescale = 8'd99; m_cnt = 8'd99;
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_step();
    bit ctrl_wr, commit;
    ctrl_wr = we && (addr == 2'd0);
    commit  = m_pending && (!m_enable || (pwm_out && !m_pout_prev) || (m_on == 8'd0));
    if (!m_enable) begin
      m_pulse = 0; m_cnt = m_prescale;
    end else if (m_cnt == 8'd0) begin
      m_pulse = 1; m_cnt = m_prescale;
    end else begin
      m_pulse = 0; m_cnt = m_cnt - 8'd1;
    end
    if (commit) begin
      m_on  = m_on_stage;
      m_off = m_off_stage;
    end
    m_sync = ctrl_wr && (wdata[2] || (m_enable && !wdata[0]));
    if (ctrl_wr && wdata[1]) m_pending = 1;
    else if (commit)         m_pending = 0;
    m_pout_prev = pwm_out;
    if (we) begin
      case (addr)
        2'd0: m_enable    = wdata[0];
        2'd1: m_on_stage  = wdata;
        2'd2: m_off_stage = wdata;
        default: m_prescale = wdata;
      endcase
    end
  endtask

  function automatic logic [7:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {6'b0, m_pending, m_enable};
      2'd1:    return m_on_stage;
      2'd2:    return m_off_stage;
      default: return m_prescale;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic apply_reset();
    we = 1'b0; pwm_out = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    write_reg(2'd0, 8'h01);
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b1;
    #2;
    model_reset();
    n_checks += 5;
    if (pwm_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_pulse: got %b expected 0", pwm_pulse); end
    if (pwm_on_reg !== 8'd0) begin n_errors++; $display("FAIL reset_on: got %h expected 00", pwm_on_reg); end
    if (pwm_off_reg !== 8'd0) begin n_errors++; $display("FAIL reset_off: got %h expected 00", pwm_off_reg); end
    if (sync_reset !== 1'b0) begin n_errors++; $display("FAIL reset_sync: got %b expected 0", sync_reset); end
    addr = 2'd3; #1;
    if (rdata !== 8'd99) begin n_errors++; $display("FAIL reset_prescale: got %0d expected 99", rdata); end
    addr = 2'd0; #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_errors++; $display("FAIL reset_ctrl: got %h expected 00", rdata); end
    reset = 1'b0;
    write_reg(2'd3, 8'h05);
    addr = 2'd3; #1;
    n_checks++;
    if (rdata !== 8'h05) begin n_errors++; $display("FAIL readback_prescale: got %h expected 05", rdata); end
  endtask

  task automatic test_prescaler();
    int ones;
    apply_reset();
    write_reg(2'd3, 8'd3);
    write_reg(2'd0, 8'h01);
    for (int k = 1; k <= 13; k++) begin
      tick();
      n_checks++;
      if (pwm_pulse !== ((k % 4 == 0) ? 1'b1 : 1'b0)) begin
        n_errors++; $display("FAIL prescale3_k%0d: got %b expected %b", k, pwm_pulse, (k % 4 == 0));
      end
    end
    write_reg(2'd3, 8'd0);
    for (int k = 0; k < 6; k++) tick();
    ones = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pwm_pulse === 1'b1) ones++;
    end
    n_checks++;
    if (ones != 5) begin n_errors++; $display("FAIL prescale0_every_cycle: got %0d pulses expected 5", ones); end
  endtask

  task automatic test_buffered_update();
    apply_reset();
    write_reg(2'd1, 8'd10);
    write_reg(2'd2, 8'd20);
    write_reg(2'd0, 8'h03);
    tick();
    n_checks += 2;
    if (pwm_on_reg !== 8'd10) begin n_errors++; $display("FAIL buf_init_on: got %0d expected 10", pwm_on_reg); end
    if (pwm_off_reg !== 8'd20) begin n_errors++; $display("FAIL buf_init_off: got %0d expected 20", pwm_off_reg); end
    write_reg(2'd1, 8'd5);
    write_reg(2'd2, 8'd7);
    write_reg(2'd0, 8'h03);
    for (int k = 0; k < 3; k++) tick();
    addr = 2'd0; #1;
    n_checks += 3;
    if (pwm_on_reg !== 8'd10) begin n_errors++; $display("FAIL buf_hold_on: got %0d expected 10", pwm_on_reg); end
    if (pwm_off_reg !== 8'd20) begin n_errors++; $display("FAIL buf_hold_off: got %0d expected 20", pwm_off_reg); end
    if (rdata !== 8'h03) begin n_errors++; $display("FAIL buf_pending_ctrl: got %h expected 03", rdata); end
    pwm_out = 1'b1;
    tick();
    n_checks += 3;
    if (pwm_on_reg !== 8'd5) begin n_errors++; $display("FAIL buf_commit_on: got %0d expected 5", pwm_on_reg); end
    if (pwm_off_reg !== 8'd7) begin n_errors++; $display("FAIL buf_commit_off: got %0d expected 7", pwm_off_reg); end
    if (rdata !== 8'h01) begin n_errors++; $display("FAIL buf_commit_ctrl: got %h expected 01", rdata); end
    pwm_out = 1'b0;
  endtask

  task automatic test_idle_commit();
    apply_reset();
    write_reg(2'd1, 8'd8);
    write_reg(2'd2, 8'd8);
    write_reg(2'd0, 8'h03);
    addr = 2'd0; #1;
    n_checks += 2;
    if (pwm_on_reg !== 8'd0) begin n_errors++; $display("FAIL idle_before_on: got %0d expected 0", pwm_on_reg); end
    if (rdata !== 8'h03) begin n_errors++; $display("FAIL idle_pending: got %h expected 03", rdata); end
    tick();
    n_checks += 3;
    if (pwm_on_reg !== 8'd8) begin n_errors++; $display("FAIL idle_commit_on: got %0d expected 8", pwm_on_reg); end
    if (pwm_off_reg !== 8'd8) begin n_errors++; $display("FAIL idle_commit_off: got %0d expected 8", pwm_off_reg); end
    if (rdata !== 8'h01) begin n_errors++; $display("FAIL idle_commit_ctrl: got %h expected 01", rdata); end
  endtask

  task automatic test_sync_reset();
    int ones;
    apply_reset();
    write_reg(2'd3, 8'd0);
    write_reg(2'd0, 8'h05);
    n_checks++;
    if (sync_reset !== 1'b1) begin n_errors++; $display("FAIL sync_force_hi: got %b expected 1", sync_reset); end
    tick();
    n_checks++;
    if (sync_reset !== 1'b0) begin n_errors++; $display("FAIL sync_force_lo: got %b expected 0", sync_reset); end
    tick();
    n_checks++;
    if (pwm_pulse !== 1'b1) begin n_errors++; $display("FAIL sync_pulse_running: got %b expected 1", pwm_pulse); end
    write_reg(2'd0, 8'h00);
    n_checks++;
    if (sync_reset !== 1'b1) begin n_errors++; $display("FAIL sync_disable_hi: got %b expected 1", sync_reset); end
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        n_checks++;
        if (sync_reset !== 1'b0) begin n_errors++; $display("FAIL sync_disable_lo: got %b expected 0", sync_reset); end
      end
      if (pwm_pulse !== 1'b0) ones++;
    end
    n_checks++;
    if (ones != 0) begin n_errors++; $display("FAIL sync_pulse_stopped: got %0d pulses expected 0", ones); end
    write_reg(2'd0, 8'h00);
    n_checks++;
    if (sync_reset !== 1'b0) begin n_errors++; $display("FAIL sync_idle_write: got %b expected 0", sync_reset); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    write_reg(2'd1, 8'd10);
    write_reg(2'd2, 8'd20);
    write_reg(2'd0, 8'h03);
    tick();
    write_reg(2'd1, 8'h33);
    write_reg(2'd2, 8'h44);
    write_reg(2'd0, 8'h03);
    tick();
    pwm_out = 1'b1;
    write_reg(2'd0, 8'h02);
    addr = 2'd0; #1;
    n_checks += 4;
    if (pwm_on_reg !== 8'h33) begin n_errors++; $display("FAIL simul_on: got %h expected 33", pwm_on_reg); end
    if (pwm_off_reg !== 8'h44) begin n_errors++; $display("FAIL simul_off: got %h expected 44", pwm_off_reg); end
    if (rdata !== 8'h02) begin n_errors++; $display("FAIL simul_pending_kept: got %h expected 02", rdata); end
    if (sync_reset !== 1'b1) begin n_errors++; $display("FAIL simul_sync: got %b expected 1", sync_reset); end
    pwm_out = 1'b0;
    tick();
    n_checks++;
    if (rdata !== 8'h00) begin n_errors++; $display("FAIL simul_disable_commit: got %h expected 00", rdata); end
  endtask

  task automatic test_random();
    logic [1:0] ra;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      we   = ($urandom_range(0, 2) == 0);
      addr = 2'($urandom);
      case (addr)
        2'd0:    wdata = {5'b0, 3'($urandom)} | (($urandom_range(0, 3) != 0) ? 8'h01 : 8'h00);
        2'd3:    wdata = 8'($urandom_range(0, 5));
        default: wdata = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) pwm_out = ~pwm_out;
      if (i == 400) begin
        we = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        pwm_out = 1'b0;
        #1;
        reset = 1'b0;
      end
      tick();
      n_checks += 5;
      if (pwm_pulse !== m_pulse) begin n_errors++; $display("FAIL rand_pulse cyc %0d: got %b expected %b", i, pwm_pulse, m_pulse); end
      if (pwm_on_reg !== m_on) begin n_errors++; $display("FAIL rand_on cyc %0d: got %h expected %h", i, pwm_on_reg, m_on); end
      if (pwm_off_reg !== m_off) begin n_errors++; $display("FAIL rand_off cyc %0d: got %h expected %h", i, pwm_off_reg, m_off); end
      if (sync_reset !== m_sync) begin n_errors++; $display("FAIL rand_sync cyc %0d: got %b expected %b", i, sync_reset, m_sync); end
      ra = 2'($urandom);
      addr = ra; #1;
      if (rdata !== model_rdata(ra)) begin
        n_errors++; $display("FAIL rand_rdata cyc %0d addr %0d: got %h expected %h", i, ra, rdata, model_rdata(ra));
      end
    end
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 8'd0; pwm_out = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_prescaler();
    test_buffered_update();
    test_idle_commit();
    test_sync_reset();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
